// File: rtl/matrix_message_source_pkg.sv
// Shared widths, message layout and head-FSM encoding for the matrix-init message source.
package matrix_message_source_pkg;

    localparam int TYPE_BITS          = 1;
    localparam int COORD_BITS         = 8;
    localparam int ELEMENT_BITS       = 32;
    localparam int MSG_BITS           = TYPE_BITS + 2 * COORD_BITS + ELEMENT_BITS;
    localparam int DEFAULT_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } head_state_t;

    // Packed MSB first: {type, x, y, element}
    typedef struct packed {
        logic [TYPE_BITS-1:0]    mtype;
        logic [COORD_BITS-1:0]   x;
        logic [COORD_BITS-1:0]   y;
        logic [ELEMENT_BITS-1:0] element;
    } msg_t;

    function automatic msg_t pack_msg(
        input logic [TYPE_BITS-1:0]    mtype,
        input logic [COORD_BITS-1:0]   x,
        input logic [COORD_BITS-1:0]   y,
        input logic [ELEMENT_BITS-1:0] element
    );
        msg_t m;
        m.mtype   = mtype;
        m.x       = x;
        m.y       = y;
        m.element = element;
        return m;
    endfunction

endpackage

// File: rtl/matrix_message_source_if.sv
// Loader-side and core-side signals of the matrix message source.
interface matrix_message_source_if
    import matrix_message_source_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
);
    localparam int COUNT_BITS = $clog2(FIFO_DEPTH + 1) + 1;

    logic [TYPE_BITS-1:0]    load_type;
    logic [COORD_BITS-1:0]   load_x_coord;
    logic [COORD_BITS-1:0]   load_y_coord;
    logic [ELEMENT_BITS-1:0] load_element;
    logic                    load_valid;
    logic                    load_ready;
    logic [TYPE_BITS-1:0]    matrix_type_out;
    logic [COORD_BITS-1:0]   matrix_x_coord_out;
    logic [COORD_BITS-1:0]   matrix_y_coord_out;
    logic [ELEMENT_BITS-1:0] matrix_element_out;
    logic                    message_out_valid;
    logic                    message_out_available;
    logic                    message_out_read;
    logic [COUNT_BITS-1:0]   fifo_count;
    logic                    overflow;
    logic                    underflow;

    modport master (
        input  load_type, load_x_coord, load_y_coord, load_element, load_valid, message_out_read,
        output load_ready, matrix_type_out, matrix_x_coord_out, matrix_y_coord_out,
               matrix_element_out, message_out_valid, message_out_available,
               fifo_count, overflow, underflow
    );

    modport slave (
        output load_type, load_x_coord, load_y_coord, load_element, load_valid, message_out_read,
        input  load_ready, matrix_type_out, matrix_x_coord_out, matrix_y_coord_out,
               matrix_element_out, message_out_valid, message_out_available,
               fifo_count, overflow, underflow
    );

endinterface

// File: rtl/matrix_message_fifo_ram.sv
// Simple dual-port message RAM with a registered read port; the array is not reset.
module matrix_message_fifo_ram
    import matrix_message_source_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  msg_t                 wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output msg_t                 rd_data
);

    msg_t mem_r [DEPTH];

    // Write port and one-cycle registered read port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/matrix_message_source.sv
// Message FIFO feeding a polled head register; the core pops one message per read strobe.
module matrix_message_source
    import matrix_message_source_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    matrix_message_source_if.master  bus
);

    localparam int ADDR_BITS  = $clog2(FIFO_DEPTH);
    localparam int COUNT_BITS = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [ADDR_BITS:0] RAM_FULL = (ADDR_BITS + 1)'(FIFO_DEPTH);

    head_state_t             state_r;
    logic [ADDR_BITS-1:0]    wr_ptr_r;
    logic [ADDR_BITS-1:0]    rd_ptr_r;
    logic [ADDR_BITS:0]      ram_count_r;
    logic [COUNT_BITS-1:0]   fifo_count_r;
    msg_t                    head_r;
    logic                    valid_r;
    logic                    available_r;
    logic                    load_ready_r;
    logic                    overflow_r;
    logic                    underflow_r;

    logic                    push_s;
    logic                    pop_s;
    logic                    rd_issue_s;
    logic [ADDR_BITS:0]      ram_count_next_s;
    logic [COUNT_BITS-1:0]   fifo_count_next_s;
    msg_t                    wr_data_s;
    msg_t                    rd_data_s;

    assign wr_data_s = pack_msg(bus.load_type, bus.load_x_coord, bus.load_y_coord, bus.load_element);

    // Transfer decode and next counts; a refill read is issued from EMPTY or on a pop in VALID
    always_comb begin
        push_s     = bus.load_valid && load_ready_r;
        pop_s      = 1'b0;
        rd_issue_s = 1'b0;
        case (state_r)
            ST_EMPTY: rd_issue_s = (ram_count_r != {(ADDR_BITS + 1){1'b0}});
            ST_FETCH: rd_issue_s = 1'b0;
            ST_VALID: begin
                pop_s      = bus.message_out_read;
                rd_issue_s = bus.message_out_read && (ram_count_r != {(ADDR_BITS + 1){1'b0}});
            end
            default:  rd_issue_s = 1'b0;
        endcase
        ram_count_next_s  = ram_count_r + (ADDR_BITS + 1)'(push_s) - (ADDR_BITS + 1)'(rd_issue_s);
        fifo_count_next_s = fifo_count_r + COUNT_BITS'(push_s) - COUNT_BITS'(pop_s);
    end

    matrix_message_fifo_ram #(
        .DEPTH     (FIFO_DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push_s),
        .wr_addr (wr_ptr_r),
        .wr_data (wr_data_s),
        .rd_en   (rd_issue_s),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_data_s)
    );

    // Head FSM, pointers, counts and sticky error flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_EMPTY;
            wr_ptr_r     <= {ADDR_BITS{1'b0}};
            rd_ptr_r     <= {ADDR_BITS{1'b0}};
            ram_count_r  <= {(ADDR_BITS + 1){1'b0}};
            fifo_count_r <= {COUNT_BITS{1'b0}};
            head_r       <= '0;
            valid_r      <= 1'b0;
            available_r  <= 1'b0;
            load_ready_r <= 1'b1;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_BITS'(1);
            end
            if (rd_issue_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_BITS'(1);
            end
            ram_count_r  <= ram_count_next_s;
            fifo_count_r <= fifo_count_next_s;
            available_r  <= (fifo_count_next_s != {COUNT_BITS{1'b0}});
            // Ready uses the post-edge count so a full RAM refuses writes for the whole next cycle
            load_ready_r <= (ram_count_next_s != RAM_FULL);
            overflow_r   <= overflow_r | (bus.load_valid & ~load_ready_r);
            underflow_r  <= underflow_r | (bus.message_out_read & (state_r != ST_VALID));
            case (state_r)
                ST_EMPTY: begin
                    valid_r <= 1'b0;
                    state_r <= rd_issue_s ? ST_FETCH : ST_EMPTY;
                end
                ST_FETCH: begin
                    head_r  <= rd_data_s;
                    valid_r <= 1'b1;
                    state_r <= ST_VALID;
                end
                ST_VALID: begin
                    if (pop_s) begin
                        valid_r <= 1'b0;
                        state_r <= rd_issue_s ? ST_FETCH : ST_EMPTY;
                    end else begin
                        valid_r <= 1'b1;
                        state_r <= ST_VALID;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

    assign bus.load_ready            = load_ready_r;
    assign bus.matrix_type_out       = head_r.mtype;
    assign bus.matrix_x_coord_out    = head_r.x;
    assign bus.matrix_y_coord_out    = head_r.y;
    assign bus.matrix_element_out    = head_r.element;
    assign bus.message_out_valid     = valid_r;
    assign bus.message_out_available = available_r;
    assign bus.fifo_count            = fifo_count_r;
    assign bus.overflow              = overflow_r;
    assign bus.underflow             = underflow_r;

endmodule

// File: tb/tb_matrix_message_source.sv
// Scoreboard bench: writers queue expected messages, a negedge monitor checks every pop in order.
module tb_matrix_message_source;
    import matrix_message_source_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    msg_t exp_q[$];

    always #5 clk = ~clk;

    matrix_message_source_if #(.FIFO_DEPTH(16)) bus ();

    matrix_message_source #(.FIFO_DEPTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every pop of a valid head must match the oldest queued message
    always @(negedge clk) begin
        if (reset_n && bus.message_out_valid && bus.message_out_read) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected actual=%0h required=none",
                         {bus.matrix_type_out, bus.matrix_x_coord_out, bus.matrix_y_coord_out, bus.matrix_element_out});
            end else begin
                msg_t e;
                msg_t a;
                e = exp_q.pop_front();
                a = pack_msg(bus.matrix_type_out, bus.matrix_x_coord_out, bus.matrix_y_coord_out, bus.matrix_element_out);
                if (a !== e) begin
                    errors++;
                    $display("FAIL pop_fields actual=%0h required=%0h", a, e);
                end
            end
        end
    end

    task automatic do_reset();
        bus.load_valid       = 1'b0;
        bus.message_out_read = 1'b0;
        reset_n = 1'b0;
        tick();
        exp_q.delete();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic set_load(input logic [TYPE_BITS-1:0] t, input logic [COORD_BITS-1:0] x,
                            input logic [COORD_BITS-1:0] y, input logic [ELEMENT_BITS-1:0] e);
        bus.load_type    = t;
        bus.load_x_coord = x;
        bus.load_y_coord = y;
        bus.load_element = e;
        bus.load_valid   = 1'b1;
    endtask

    // One-cycle write that the bench expects to be accepted
    task automatic write_msg(input logic [TYPE_BITS-1:0] t, input logic [COORD_BITS-1:0] x,
                             input logic [COORD_BITS-1:0] y, input logic [ELEMENT_BITS-1:0] e);
        set_load(t, x, y, e);
        exp_q.push_back(pack_msg(t, x, y, e));
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.message_out_valid && n < 20) begin
            tick();
            n++;
        end
        chk(name, {63'd0, bus.message_out_valid}, 64'd1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (bus.fifo_count != '0 && n < 200) begin
            bus.message_out_read = bus.message_out_valid;
            tick();
            n++;
        end
        bus.message_out_read = 1'b0;
        chk(name, 64'(bus.fifo_count), 64'd0);
        chk({name, "_q"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        bus.load_type        = '0;
        bus.load_x_coord     = '0;
        bus.load_y_coord     = '0;
        bus.load_element     = '0;
        bus.load_valid       = 1'b0;
        bus.message_out_read = 1'b0;
        do_reset();

        chk("rst_count",     64'(bus.fifo_count),                 64'd0);
        chk("rst_valid",     {63'd0, bus.message_out_valid},      64'd0);
        chk("rst_available", {63'd0, bus.message_out_available},  64'd0);
        chk("rst_ready",     {63'd0, bus.load_ready},             64'd1);
        chk("rst_flags",     {62'd0, bus.overflow, bus.underflow}, 64'd0);

        // Single message latency and pop
        write_msg(1'b1, 8'd3, 8'd5, 32'hDEADBEEF);
        chk("single_avail_n",  {63'd0, bus.message_out_available}, 64'd1);
        chk("single_count_n",  64'(bus.fifo_count),                64'd1);
        chk("single_valid_n",  {63'd0, bus.message_out_valid},     64'd0);
        tick();
        chk("single_valid_n1", {63'd0, bus.message_out_valid},     64'd0);
        tick();
        chk("single_valid_n2", {63'd0, bus.message_out_valid},     64'd1);
        bus.message_out_read = 1'b1;
        tick();
        bus.message_out_read = 1'b0;
        chk("single_pop_valid", {63'd0, bus.message_out_valid},     64'd0);
        chk("single_pop_avail", {63'd0, bus.message_out_available}, 64'd0);
        chk("single_pop_count", 64'(bus.fifo_count),                64'd0);

        // Fill: 16 back-to-back, head drains one, 17th fits, 18th overflows
        do_reset();
        for (int i = 0; i < 16; i++) begin
            write_msg(1'b0, 8'(i), 8'(i + 1), 32'h100 + 32'(i));
        end
        chk("fill16_count", 64'(bus.fifo_count),        64'd16);
        chk("fill16_ready", {63'd0, bus.load_ready},    64'd1);
        write_msg(1'b1, 8'hAA, 8'hBB, 32'h0000_0117);
        chk("fill17_count", 64'(bus.fifo_count),        64'd17);
        chk("fill17_ready", {63'd0, bus.load_ready},    64'd0);
        chk("fill17_ovf",   {63'd0, bus.overflow},      64'd0);
        set_load(1'b1, 8'hCC, 8'hDD, 32'h0000_0118);
        tick();
        bus.load_valid = 1'b0;
        chk("fill18_ovf",   {63'd0, bus.overflow},      64'd1);
        chk("fill18_count", 64'(bus.fifo_count),        64'd17);
        drain("fill_drain");

        // Streaming 0..39 under backpressure with pops whenever valid
        do_reset();
        begin
            int wr_i = 0;
            int n = 0;
            while ((wr_i < 40 || bus.fifo_count != '0) && n < 400) begin
                if (wr_i < 40 && bus.load_ready) begin
                    set_load(1'b0, 8'd7, 8'd9, 32'(wr_i));
                    exp_q.push_back(pack_msg(1'b0, 8'd7, 8'd9, 32'(wr_i)));
                    wr_i++;
                end else begin
                    bus.load_valid = 1'b0;
                end
                bus.message_out_read = bus.message_out_valid;
                tick();
                n++;
            end
            bus.load_valid       = 1'b0;
            bus.message_out_read = 1'b0;
            chk("stream_written", 64'(wr_i), 64'd40);
        end
        chk("stream_count", 64'(bus.fifo_count),             64'd0);
        chk("stream_q",     64'(exp_q.size()),               64'd0);
        chk("stream_flags", {62'd0, bus.overflow, bus.underflow}, 64'd0);

        // Pop during the FETCH cycle after a pop
        do_reset();
        write_msg(1'b0, 8'd1, 8'd2, 32'h0000_0A01);
        write_msg(1'b1, 8'd3, 8'd4, 32'h0000_0A02);
        wait_valid("udf_first_valid");
        bus.message_out_read = 1'b1;
        tick();
        chk("udf_fetch_valid", {63'd0, bus.message_out_valid}, 64'd0);
        tick();
        bus.message_out_read = 1'b0;
        chk("udf_flag",  {63'd0, bus.underflow},  64'd1);
        chk("udf_count", 64'(bus.fifo_count),     64'd1);
        drain("udf_drain");

        // Simultaneous push and pop at count 4
        do_reset();
        for (int i = 0; i < 4; i++) begin
            write_msg(1'b0, 8'd0, 8'(i), 32'h0000_0B00 + 32'(i));
        end
        wait_valid("sim_valid");
        chk("sim_count_pre", 64'(bus.fifo_count), 64'd4);
        bus.message_out_read = 1'b1;
        write_msg(1'b1, 8'd0, 8'd4, 32'h0000_0B04);
        bus.message_out_read = 1'b0;
        chk("sim_count_post", 64'(bus.fifo_count), 64'd4);
        drain("sim_drain");

        // Reset with six queued messages and a sticky underflow
        do_reset();
        bus.message_out_read = 1'b1;
        tick();
        bus.message_out_read = 1'b0;
        for (int i = 0; i < 6; i++) begin
            write_msg(1'b0, 8'd5, 8'(i), 32'h0000_0C00 + 32'(i));
        end
        chk("rst6_pre_count", 64'(bus.fifo_count), 64'd6);
        chk("rst6_pre_udf",   {63'd0, bus.underflow}, 64'd1);
        reset_n = 1'b0;
        tick();
        exp_q.delete();
        chk("rst6_count", 64'(bus.fifo_count),                  64'd0);
        chk("rst6_valid", {63'd0, bus.message_out_valid},       64'd0);
        chk("rst6_avail", {63'd0, bus.message_out_available},   64'd0);
        chk("rst6_flags", {62'd0, bus.overflow, bus.underflow}, 64'd0);
        chk("rst6_ready", {63'd0, bus.load_ready},              64'd1);
        reset_n = 1'b1;
        tick();
        tick();
        chk("rst6_post_count", 64'(bus.fifo_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
